// File: rtl/i2s_pkg.sv
// i2s_pkg: shared sample width, controller states and stereo frame type
package i2s_pkg;
  localparam int DATA_W = 24;
  typedef enum logic [2:0] {IDLE, SYNC, WARMUP, RUN, DRAIN} i2s_rx_state_e;
  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } i2s_frame_t;
endpackage

// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo: 2-entry stereo frame FIFO with valid/ready output side
module i2s_frame_fifo
  import i2s_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  i2s_frame_t data_i,
  output logic       full_o,
  output i2s_frame_t data_o,
  output logic       valid_o,
  input  logic       ready_i
);
  i2s_frame_t mem_q [2];
  i2s_frame_t mem_d [2];
  logic wr_q, wr_d, rd_q, rd_d, pop, push;
  logic [1:0] cnt_q, cnt_d;
  assign valid_o = cnt_q != 2'd0;
  assign full_o = cnt_q[1];
  assign data_o = mem_q[rd_q];
  always_comb begin
    pop = valid_o & ready_i;
    push = push_i & (~full_o | pop);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = data_i;
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/i2s_rx_ctrl.sv
// i2s_rx_ctrl: pairs I2S receiver words into stereo frames and queues them for a consumer
module i2s_rx_ctrl #(
  parameter int DATA_W = i2s_pkg::DATA_W,
  parameter int CNT_W = 16,
  parameter int WARMUP_FRAMES = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [CNT_W-1:0]  frame_count_i,
  output logic              rx_enable_o,
  input  logic [DATA_W-1:0] rx_sample_i,
  input  logic              rx_new_sample_i,
  input  logic              rx_lrclk_i,
  output logic [DATA_W-1:0] frame_left_o,
  output logic [DATA_W-1:0] frame_right_o,
  output logic              frame_valid_o,
  input  logic              frame_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  input  logic              clear_ovf_i
);
  import i2s_pkg::*;
  i2s_rx_state_e state_q, state_d;
  i2s_frame_t frame_q, frame_d, head;
  logic [DATA_W-1:0] held_q, held_d;
  logic [CNT_W-1:0] target_q, target_d, n_q, n_d, warm_q, warm_d;
  logic new_q, held_v_q, held_v_d, stop_pend_q, stop_pend_d, push_q, push_d;
  logic done_q, done_d, ovf_q, ovf_d;
  logic ev_l, ev_r, complete, full, drop;
  assign rx_enable_o = state_q inside {SYNC, WARMUP, RUN};
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign overflow_o = ovf_q;
  assign frame_left_o = head.left;
  assign frame_right_o = head.right;
  always_comb begin
    ev_l = rx_new_sample_i & ~new_q & rx_lrclk_i;
    ev_r = rx_new_sample_i & ~new_q & ~rx_lrclk_i;
    complete = ev_r & held_v_q;
    drop = push_q & full & ~(frame_valid_o & frame_ready_i);
    ovf_d = (ovf_q & ~clear_ovf_i) | drop;
    state_d = state_q;
    held_d = ev_l && rx_enable_o ? rx_sample_i : held_q;
    held_v_d = rx_enable_o ? (held_v_q | ev_l) & ~complete : held_v_q;
    target_d = target_q;
    n_d = n_q;
    warm_d = warm_q;
    stop_pend_d = stop_pend_q;
    push_d = 1'b0;
    frame_d = frame_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start_i && !stop_i) begin
        state_d = SYNC;
        target_d = frame_count_i;
        n_d = '0;
        warm_d = '0;
        stop_pend_d = 1'b0;
        held_v_d = 1'b0;
      end
      SYNC: if (stop_i) state_d = DRAIN;
        else if (ev_l) state_d = WARMUP_FRAMES == 0 ? RUN : WARMUP;
      WARMUP: if (stop_i) state_d = DRAIN;
        else if (complete) begin
          warm_d = warm_q + 1'b1;
          if (warm_d == CNT_W'(WARMUP_FRAMES)) state_d = RUN;
        end
      RUN: if (complete) begin
          push_d = 1'b1;
          frame_d.left = held_q;
          frame_d.right = rx_sample_i;
          n_d = n_q + 1'b1;
          if (stop_pend_q || stop_i || (target_q != '0 && n_d == target_q)) state_d = DRAIN;
        end else if (stop_i) begin
          // a half-received frame is finished before draining
          stop_pend_d = held_v_q;
          if (!held_v_q) state_d = DRAIN;
        end
      DRAIN: if (!push_q && !frame_valid_o) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      frame_q <= '0;
      held_q <= '0;
      target_q <= '0;
      n_q <= '0;
      warm_q <= '0;
      new_q <= 1'b0;
      held_v_q <= 1'b0;
      stop_pend_q <= 1'b0;
      push_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      held_q <= held_d;
      target_q <= target_d;
      n_q <= n_d;
      warm_q <= warm_d;
      new_q <= rx_new_sample_i;
      held_v_q <= held_v_d;
      stop_pend_q <= stop_pend_d;
      push_q <= push_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
  i2s_frame_fifo u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push_i(push_q),
    .data_i(frame_q),
    .full_o(full),
    .data_o(head),
    .valid_o(frame_valid_o),
    .ready_i(frame_ready_i)
  );
endmodule

// File: doc/i2s_rx_ctrl.md
I2S_RX_CTRL -- requirements
Module: i2s_rx_ctrl

Interface
REQ-001 Parameter DATA_W, default 24, sample width; matches the receiver's audio_data_o.
REQ-002 Parameter CNT_W, default 16, width of the frame counter.
REQ-003 Parameter WARMUP_FRAMES, default 1, stereo frames discarded after each start.
REQ-004 Port clk_i, input, 1, single system clock; all logic on posedge.
REQ-005 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 Port start_i, input, 1, one-cycle capture request.
REQ-007 Port stop_i, input, 1, one-cycle stop request.
REQ-008 Port frame_count_i, input, CNT_W, frames to deliver; 0 means continuous; sampled on accepted start.
REQ-009 Port rx_enable_o, output, 1, drives the receiver's enable_i.
REQ-010 Port rx_sample_i, input, DATA_W, receiver audio_data_o.
REQ-011 Port rx_new_sample_i, input, 1, receiver new_sample_o; may be wider than one cycle.
REQ-012 Port rx_lrclk_i, input, 1, receiver lrclk_o.
REQ-013 Port frame_left_o, output, DATA_W, head-of-FIFO left word.
REQ-014 Port frame_right_o, output, DATA_W, head-of-FIFO right word.
REQ-015 Port frame_valid_o, output, 1, head frame valid.
REQ-016 Port frame_ready_i, input, 1, consumer ready; transfer when valid and ready are both high.
REQ-017 Port busy_o, output, 1, high in any state other than IDLE.
REQ-018 Port done_o, output, 1, one-cycle pulse on return to IDLE.
REQ-019 Port overflow_o, output, 1, sticky dropped-frame flag.
REQ-020 Port clear_ovf_i, input, 1, clears overflow_o.

Function
REQ-021 The block SHALL detect a new sample on the rising edge of rx_new_sample_i, using a registered previous value; one event per edge.
REQ-022 At an event, the sample SHALL be left if rx_lrclk_i is 1 (word completed during the low phase) and right if rx_lrclk_i is 0.
REQ-023 The FSM SHALL have exactly the states IDLE, SYNC, WARMUP, RUN and DRAIN.
REQ-024 IDLE: a start_i with stop_i low SHALL latch frame_count_i, assert rx_enable_o and enter SYNC; start_i outside IDLE SHALL be ignored.
REQ-025 SYNC: right events SHALL be ignored; the first left event SHALL be held and the FSM SHALL enter WARMUP, or RUN if WARMUP_FRAMES is 0.
REQ-026 A stereo frame SHALL be a held left word followed by a right event.
REQ-027 Left after left SHALL replace the held word.
REQ-028 Right with no held left SHALL be discarded.
REQ-029 WARMUP: the block SHALL discard WARMUP_FRAMES complete frames, then enter RUN.
REQ-030 RUN: each complete frame SHALL be pushed into the FIFO in the cycle after the right event.
REQ-031 frame_valid_o SHALL rise the cycle after the push.
REQ-032 When the FIFO is full at push time, the new frame SHALL be dropped, overflow_o set, and the dropped frame counted toward frame_count.
REQ-033 With frame_count nonzero, completing the Nth frame SHALL enter DRAIN.
REQ-034 stop_i in SYNC or WARMUP SHALL go directly to DRAIN.
REQ-035 stop_i in RUN SHALL finish a held left word and its right word, then enter DRAIN.
REQ-036 stop_i SHALL win over a simultaneous start_i.
REQ-037 DRAIN: rx_enable_o SHALL deassert on entry, and the state SHALL hold until the FIFO is empty, then enter IDLE and pulse done_o.
REQ-038 The FIFO SHALL hold 2 frames; simultaneous push and pop on a full FIFO SHALL succeed without overflow.
REQ-039 clear_ovf_i SHALL clear overflow_o; a simultaneous overflow SHALL leave overflow_o set.

Reset
REQ-040 rst_ni low SHALL force, asynchronously, state IDLE and rx_enable_o=0, frame_valid_o=0, busy_o=0, done_o=0 and overflow_o=0.
REQ-041 rst_ni low SHALL also clear the FIFO, counters and held word, including mid-RUN; frame_left_o and frame_right_o SHALL reset to 0.

Structure
REQ-042 Package i2s_pkg SHALL hold DATA_W, the state enum i2s_rx_state_e and the struct i2s_frame_t {left, right}.
REQ-043 Sub-module i2s_frame_fifo SHALL implement the 2-entry i2s_frame_t FIFO with valid/ready.

Verification
REQ-044 Bench SHALL drive frame_count=3, WARMUP_FRAMES=1, ready high, with L/R pairs (0x20F3FF,0x000001), (0x20F3FB,0x000002), (0x20F3F7,0x000003), (0x111111,0x222222) -> pair 1 dropped; exactly 3 frames out with pairs 2-4; one done_o pulse; rx_enable_o low afterward.
REQ-045 Bench SHALL hold ready low for 4 frames in continuous mode -> 2 frames held, overflow_o=1; clear_ovf_i -> 0; releasing ready yields the first 2 frames in order.
REQ-046 Bench SHALL stop_i mid-frame after a left of 0xABCDEF -> the frame completes with the next right, then DRAIN, then IDLE once the FIFO is drained.
REQ-047 Bench SHALL pulse start_i and stop_i in the same cycle -> state stays IDLE and rx_enable_o stays 0.
REQ-048 Bench SHALL assert rst_ni low for 3 cycles in RUN with 1 frame queued -> all outputs at reset values immediately; a restart yields fresh frames only.
REQ-049 Bench SHALL present a right event first in SYNC, then 2 consecutive left events -> the right event is ignored and the second left word pairs with the next right word.
